// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - digit-serial d = a - b - bin with start/busy/done handshake
// Optional macro SERIAL_SUBTRACTOR_SATURATE_EN clamps d to zero when the final borrow is set.
module serial_subtractor #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] d,
  output logic             br,
  output logic             ovf
);
  localparam int NUM = WIDTH / DIGIT;
  localparam int CW  = (NUM > 1) ? $clog2(NUM) : 1;
  localparam logic [CW-1:0] LAST = CW'(NUM - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_sh, b_sh, res_sh, res_nxt, d_fin;
  logic             borrow;
  logic [CW-1:0]    cnt;
  logic             a_msb, b_msb;
  logic [DIGIT:0]   dig_diff;
  logic             last_dig;
  logic             ovf_nxt;

  // One digit of the subtraction; bit DIGIT is the digit's borrow-out.
  assign dig_diff = {1'b0, a_sh[DIGIT-1:0]} - {1'b0, b_sh[DIGIT-1:0]} - {{DIGIT{1'b0}}, borrow};
  assign last_dig = (cnt == LAST);

  generate
    if (DIGIT == WIDTH) begin : g_single
      assign res_nxt = dig_diff[DIGIT-1:0];
    end else begin : g_multi
      assign res_nxt = {dig_diff[DIGIT-1:0], res_sh[WIDTH-1:DIGIT]};
    end
  endgenerate

  // Overflow always judged on the unclamped difference.
  assign ovf_nxt = (a_msb ^ b_msb) & (a_msb ^ res_nxt[WIDTH-1]);

`ifdef SERIAL_SUBTRACTOR_SATURATE_EN
  assign d_fin = dig_diff[DIGIT] ? '0 : res_nxt;
`else
  assign d_fin = res_nxt;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nxt = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (last_dig) state_nxt = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sh   <= '0;
      b_sh   <= '0;
      res_sh <= '0;
      borrow <= 1'b0;
      cnt    <= '0;
      a_msb  <= 1'b0;
      b_msb  <= 1'b0;
      d      <= '0;
      br     <= 1'b0;
      ovf    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_sh   <= a;
            b_sh   <= b;
            res_sh <= '0;
            borrow <= bin;
            cnt    <= '0;
            a_msb  <= a[WIDTH-1];
            b_msb  <= b[WIDTH-1];
          end
        end
        RUN: begin
          a_sh   <= a_sh >> DIGIT;
          b_sh   <= b_sh >> DIGIT;
          res_sh <= res_nxt;
          borrow <= dig_diff[DIGIT];
          cnt    <= cnt + CW'(1);
          // Published results change only here, on the last digit.
          if (last_dig) begin
            d   <= d_fin;
            br  <= dig_diff[DIGIT];
            ovf <= ovf_nxt;
          end
        end
        default: ;
      endcase
    end
  end
endmodule
